// File: rtl/float_pkg.sv
// Shared definitions for the recip_fixup block: FSM and step-direction encodings, default
// widths, the residual width rule and the saturated-result constant.
package float_pkg;

  localparam int unsigned NumberWidthDef = 24;
  localparam int unsigned MaxCorrDef     = 4;

  // Residual 2^W - d*r needs 2W bits of magnitude plus sign and one bit of headroom.
  function automatic int unsigned rem_width(input int unsigned w);
    return 2 * w + 2;
  endfunction

  localparam int unsigned RemWidthDef = rem_width(NumberWidthDef);

  // Result returned for d==0 (error) and d==1 (saturated, 2^W does not fit).
  localparam logic [NumberWidthDef-1:0] SatOnesDef = '1;

  typedef enum logic [1:0] {
    StIdle,
    StMul,
    StCorr,
    StDone
  } state_e;

  typedef enum logic [1:0] {
    DirHold,
    DirDown,
    DirUp
  } dir_e;

endpackage

// File: rtl/recip_fixup_step.sv
// One correction step of the reciprocal fix-up. Given the signed residual
// rem = 2^W - d*r, decide whether r is already exact and, if not, move r
// one unit toward floor(2^W / d) while keeping rem consistent.
module recip_fixup_step
  import float_pkg::*;
#(
  parameter int unsigned NUMBER_WIDTH = NumberWidthDef,
  parameter int unsigned REM_WIDTH    = RemWidthDef
) (
  input  logic [REM_WIDTH-1:0]    rem_i,
  input  logic [NUMBER_WIDTH-1:0] r_i,
  input  logic [NUMBER_WIDTH-1:0] d_i,
  output logic [REM_WIDTH-1:0]    rem_o,
  output logic [NUMBER_WIDTH-1:0] r_o,
  output logic                    in_range_o,
  output dir_e                    dir_o
);

  logic [REM_WIDTH-1:0] d_ext;
  logic                 rem_neg;
  logic                 rem_ge_d;

  // Classify the residual and form the stepped r/rem; two's complement keeps rem exact.
  always_comb begin
    d_ext      = {{(REM_WIDTH - NUMBER_WIDTH){1'b0}}, d_i};
    rem_neg    = rem_i[REM_WIDTH-1];
    rem_ge_d   = !rem_neg && (rem_i >= d_ext);
    in_range_o = !rem_neg && !rem_ge_d;
    dir_o      = DirHold;
    rem_o      = rem_i;
    r_o        = r_i;
    if (rem_neg) begin
      // r too large: d*r overshoots 2^W.
      dir_o = DirDown;
      rem_o = rem_i + d_ext;
      r_o   = r_i - 1'b1;
    end else if (rem_ge_d) begin
      // r too small: at least one more d fits under 2^W.
      dir_o = DirUp;
      rem_o = rem_i - d_ext;
      r_o   = r_i + 1'b1;
    end
  end

endmodule

// File: rtl/recip_fixup.sv
// Reciprocal fix-up: corrects an approximate reciprocal r of divisor d to the exact
// floor(2^NUMBER_WIDTH / d) using one multiply and up to MAX_CORR +/-1 steps.
// One job in flight, valid/ready on both sides. MAX_CORR must be at least 1.
// Optional build macro RECIP_FIXUP_STATS_EN adds out_corr, the step count of the result.
module recip_fixup
  import float_pkg::*;
#(
  parameter int unsigned NUMBER_WIDTH = NumberWidthDef,
  parameter int unsigned MAX_CORR     = MaxCorrDef
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUMBER_WIDTH-1:0] in_d,
  input  logic [NUMBER_WIDTH-1:0] in_r,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NUMBER_WIDTH-1:0] out_r,
  output logic                    out_err
`ifdef RECIP_FIXUP_STATS_EN
  ,
  output logic [$clog2(MAX_CORR+1)-1:0] out_corr
`endif
);

  localparam int unsigned REM_WIDTH = rem_width(NUMBER_WIDTH);
  localparam int unsigned KW        = $clog2(MAX_CORR + 1);
  localparam int unsigned PadW      = REM_WIDTH - NUMBER_WIDTH;

  localparam logic [KW-1:0]        KMax    = KW'(MAX_CORR);
  localparam logic [REM_WIDTH-1:0] TwoPowW =
      {{(REM_WIDTH - NUMBER_WIDTH - 1){1'b0}}, 1'b1, {NUMBER_WIDTH{1'b0}}};

  state_e                  state_q, state_d;
  logic [NUMBER_WIDTH-1:0] d_q, d_d;
  logic [NUMBER_WIDTH-1:0] r_q, r_d;
  logic [REM_WIDTH-1:0]    rem_q, rem_d;
  logic [KW-1:0]           k_q, k_d;
  logic                    err_q, err_d;

  logic [REM_WIDTH-1:0]    prod;
  logic [REM_WIDTH-1:0]    step_rem;
  logic [NUMBER_WIDTH-1:0] step_r;
  logic                    step_in_range;
  dir_e                    step_dir;
  logic                    unused_dir;

  recip_fixup_step #(
    .NUMBER_WIDTH(NUMBER_WIDTH),
    .REM_WIDTH   (REM_WIDTH)
  ) u_step (
    .rem_i     (rem_q),
    .r_i       (r_q),
    .d_i       (d_q),
    .rem_o     (step_rem),
    .r_o       (step_r),
    .in_range_o(step_in_range),
    .dir_o     (step_dir)
  );

  // Direction is exported by the step for observation; the FSM only needs in_range.
  assign unused_dir = ^step_dir;

  // Single multiply, zero-extended to the residual width so the product never truncates.
  always_comb begin
    prod = {{PadW{1'b0}}, d_q} * {{PadW{1'b0}}, r_q};
  end

  // Ready only in IDLE and never while reset is held.
  always_comb begin
    in_ready  = (state_q == StIdle) && resetn;
    out_valid = (state_q == StDone);
    out_r     = r_q;
    out_err   = err_q;
  end

`ifdef RECIP_FIXUP_STATS_EN
  // Step count of the held result; cleared on accept so the d<=1 paths report 0.
  always_comb begin
    out_corr = k_q;
  end
`endif

  // Next-state and datapath control for the IDLE -> MUL -> CORR -> DONE loop.
  always_comb begin
    state_d = state_q;
    d_d     = d_q;
    r_d     = r_q;
    rem_d   = rem_q;
    k_d     = k_q;
    err_d   = err_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid && in_ready) begin
          d_d   = in_d;
          r_d   = in_r;
          k_d   = '0;
          err_d = 1'b0;
          if (in_d == '0) begin
            r_d     = '1;
            err_d   = 1'b1;
            state_d = StDone;
          end else if (in_d == NUMBER_WIDTH'(1)) begin
            // 2^W itself is not representable; saturate without error.
            r_d     = '1;
            state_d = StDone;
          end else begin
            state_d = StMul;
          end
        end
      end
      StMul: begin
        rem_d   = TwoPowW - prod;
        state_d = StCorr;
      end
      StCorr: begin
        if (step_in_range) begin
          state_d = StDone;
        end else if (k_q == KMax) begin
          // Budget spent and still wrong: hand back the current r flagged as an error.
          err_d   = 1'b1;
          state_d = StDone;
        end else begin
          rem_d = step_rem;
          r_d   = step_r;
          k_d   = k_q + KW'(1);
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers; reset discards any job in flight.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= StIdle;
      d_q     <= '0;
      r_q     <= '0;
      rem_q   <= '0;
      k_q     <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      d_q     <= d_d;
      r_q     <= r_d;
      rem_q   <= rem_d;
      k_q     <= k_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_recip_fixup.sv
// Self-checking bench for recip_fixup. Expected results come from a reference model that
// computes floor(2^24/d) directly and derives result, error flag, step count and latency
// from the distance between the supplied r and that exact value.
module tb_recip_fixup;

  localparam int W  = 24;
  localparam int MC = 4;
  localparam logic [W-1:0] Ones = '1;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_d = '0;
  logic [W-1:0] in_r = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_r;
  logic         out_err;
`ifdef RECIP_FIXUP_STATS_EN
  logic [2:0]   out_corr;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  recip_fixup #(
    .NUMBER_WIDTH(W),
    .MAX_CORR    (MC)
  ) dut (
    .clk      (clk),
    .resetn   (resetn),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_d     (in_d),
    .in_r     (in_r),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_r    (out_r),
    .out_err  (out_err)
`ifdef RECIP_FIXUP_STATS_EN
    ,
    .out_corr (out_corr)
`endif
  );

  // Reference: exact reciprocal, then how far r is from it decides everything else.
  task automatic model(input logic [W-1:0] d, input logic [W-1:0] r,
                       output logic [W-1:0] er, output logic ee, output int ek,
                       output int elat);
    longint big_r, diff, ad;
    if (d == 0) begin
      er = Ones; ee = 1'b1; ek = 0; elat = 1;
    end else if (d == 1) begin
      er = Ones; ee = 1'b0; ek = 0; elat = 1;
    end else begin
      big_r = (longint'(1) << W) / longint'(d);
      diff  = longint'(r) - big_r;
      ad    = (diff < 0) ? -diff : diff;
      if (ad <= MC) begin
        er = big_r[W-1:0]; ee = 1'b0; ek = int'(ad); elat = 3 + int'(ad);
      end else begin
        diff = (diff < 0) ? longint'(r) + MC : longint'(r) - MC;
        er = diff[W-1:0]; ee = 1'b1; ek = MC; elat = 3 + MC;
      end
    end
  endtask

  // Drive one job, wait for its result, observe it and accept it. lat=0 means never accepted.
  task automatic do_job(input logic [W-1:0] d, input logic [W-1:0] r,
                        output logic [W-1:0] o_r, output logic o_err, output int o_k,
                        output int lat);
    int n = 0;
    o_r = '0; o_err = 1'b0; o_k = 0; lat = 0;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) return;
    in_valid = 1'b1; in_d = d; in_r = r;
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1; lat++;
    end
    o_r = out_r; o_err = out_err;
`ifdef RECIP_FIXUP_STATS_EN
    o_k = int'(out_corr);
`endif
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    total++;
    if ({out_valid, in_ready, out_err} !== 3'b000) begin
      bad++;
      $display("FAIL reset_ctrl got valid/ready/err=%b want 000", {out_valid, in_ready, out_err});
    end
    total++;
    if (out_r !== '0) begin
      bad++; $display("FAIL reset_out_r got %h want 000000", out_r);
    end
    @(posedge clk); #1;
    resetn = 1'b1;
    #1;
    total++;
    if (in_ready !== 1'b1) begin
      bad++; $display("FAIL reset_release_ready got %b want 1", in_ready);
    end
  endtask

  task automatic test_directed();
    logic [W-1:0] td[6]  = '{24'd3, 24'd3, 24'd0, 24'd1, 24'd3, 24'd3};
    logic [W-1:0] tr[6]  = '{24'd5592405, 24'd5592403, 24'd123, 24'd7, 24'd5592395, 24'd5592409};
    logic [W-1:0] xr[6]  = '{24'd5592405, 24'd5592405, 24'hFFFFFF, 24'hFFFFFF, 24'd5592399,
                             24'd5592405};
    logic         xe[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    int           xk[6]  = '{0, 2, 0, 0, 4, 4};
    int           xl[6]  = '{3, 5, 1, 1, 7, 7};
    logic [W-1:0] o_r;
    logic         o_e;
    int           o_k, lat;
    for (int i = 0; i < 6; i++) begin
      do_job(td[i], tr[i], o_r, o_e, o_k, lat);
      total++;
      if (o_r !== xr[i] || o_e !== xe[i] || lat != xl[i]) begin
        bad++;
        $display("FAIL directed_%0d got r=%0d err=%b lat=%0d want r=%0d err=%b lat=%0d",
                 i, o_r, o_e, lat, xr[i], xe[i], xl[i]);
      end
`ifdef RECIP_FIXUP_STATS_EN
      total++;
      if (o_k != xk[i]) begin
        bad++; $display("FAIL directed_corr_%0d got %0d want %0d", i, o_k, xk[i]);
      end
`else
      if (o_k != 0) $display("note: unexpected corr %0d without stats (%0d)", o_k, xk[i]);
`endif
    end
  endtask

  task automatic test_backpressure();
    int n = 0;
    in_valid = 1'b1; in_d = 24'd3; in_r = 24'd5592403;
    @(posedge clk); #1;
    in_valid = 1'b0;
    while (!out_valid && n < 50) begin
      @(posedge clk); #1; n++;
    end
    for (int i = 0; i < 5; i++) begin
      total++;
      if ({out_valid, in_ready} !== 2'b10 || out_r !== 24'd5592405 || out_err !== 1'b0) begin
        bad++;
        $display("FAIL hold_%0d got valid=%b ready=%b r=%0d err=%b want 1 0 5592405 0",
                 i, out_valid, in_ready, out_r, out_err);
      end
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    total++;
    if ({out_valid, in_ready} !== 2'b01) begin
      bad++; $display("FAIL hold_release got valid/ready=%b want 01", {out_valid, in_ready});
    end
  endtask

  task automatic test_reset_mid();
    logic [W-1:0] o_r, er;
    logic         o_e, ee;
    int           o_k, lat, ek, el;
    in_valid = 1'b1; in_d = 24'd3; in_r = 24'd5592395;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    resetn = 1'b0;
    #1;
    total++;
    if ({out_valid, in_ready, out_err} !== 3'b000 || out_r !== '0) begin
      bad++;
      $display("FAIL midreset_hold got valid/ready/err=%b r=%h want 000 000000",
               {out_valid, in_ready, out_err}, out_r);
    end
    repeat (2) @(posedge clk);
    #2;
    resetn = 1'b1;
    #1;
    total++;
    if ({out_valid, in_ready} !== 2'b01) begin
      bad++; $display("FAIL midreset_release got valid/ready=%b want 01", {out_valid, in_ready});
    end
    model(24'd5, 24'd3355441, er, ee, ek, el);
    do_job(24'd5, 24'd3355441, o_r, o_e, o_k, lat);
    total++;
    if (o_r !== er || o_e !== ee || lat != el) begin
      bad++;
      $display("FAIL midreset_next got r=%0d err=%b lat=%0d want r=%0d err=%b lat=%0d",
               o_r, o_e, lat, er, ee, el);
    end
  endtask

  // Mix of near-miss approximations, far-off values and d<=1 corner cases.
  task automatic pick(output logic [W-1:0] d, output logic [W-1:0] r);
    longint big_r, cand;
    int     off, mode;
    mode = int'($urandom_range(0, 9));
    if (mode == 0) begin
      d = W'($urandom_range(0, 1));
      r = W'($urandom);
    end else begin
      d = (mode < 5) ? W'($urandom_range(2, 64)) : W'($urandom_range(2, 24'hFFFFFF));
      big_r = (longint'(1) << W) / longint'(d);
      if (mode == 9) begin
        r = W'($urandom);
      end else begin
        off  = int'($urandom_range(0, 12)) - 6;
        cand = big_r + off;
        if (cand < 0 || cand > longint'(Ones)) cand = big_r;
        r = cand[W-1:0];
      end
    end
  endtask

  task automatic test_random();
    logic [W-1:0] d, r, o_r, er;
    logic         o_e, ee;
    int           o_k, lat, ek, el;
    for (int i = 0; i < 60; i++) begin
      pick(d, r);
      model(d, r, er, ee, ek, el);
      do_job(d, r, o_r, o_e, o_k, lat);
      total++;
      if (o_r !== er || o_e !== ee || lat != el) begin
        bad++;
        $display("FAIL random_%0d d=%0d r=%0d got r=%0d err=%b lat=%0d want r=%0d err=%b lat=%0d",
                 i, d, r, o_r, o_e, lat, er, ee, el);
      end
`ifdef RECIP_FIXUP_STATS_EN
      total++;
      if (o_k != ek) begin
        bad++; $display("FAIL random_corr_%0d got %0d want %0d", i, o_k, ek);
      end
`endif
    end
  endtask

  // Jobs issued as soon as in_ready allows: each should cost exactly latency+1 cycles.
  task automatic test_back_to_back();
    logic [W-1:0] d, r, o_r, er;
    logic         o_e, ee;
    int           o_k, lat, ek, el, start, expect_cycles;
    expect_cycles = 0;
    start = cyc;
    for (int i = 0; i < 10; i++) begin
      pick(d, r);
      model(d, r, er, ee, ek, el);
      expect_cycles += el + 1;
      do_job(d, r, o_r, o_e, o_k, lat);
      total++;
      if (o_r !== er || o_e !== ee || in_ready !== 1'b1) begin
        bad++;
        $display("FAIL b2b_%0d got r=%0d err=%b ready=%b want r=%0d err=%b ready=1",
                 i, o_r, o_e, in_ready, er, ee);
      end
    end
    total++;
    if (cyc - start != expect_cycles) begin
      bad++;
      $display("FAIL b2b_throughput got %0d cycles want %0d", cyc - start, expect_cycles);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_random();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
